// File: rtl/whiz_graphics.sv
// DMG-style graphics peripheral: OAM, VRAM and LCD register file on the DataBus,
// plus the dot/scanline timing that drives the renderer strobes.
module whiz_graphics #(
    parameter int unsigned          ADDR_SIZE     = 16,
    parameter int unsigned          DATA_SIZE     = 8,
    parameter logic [ADDR_SIZE-1:0] OAM_LOC       = 16'hFE00,
    parameter int unsigned          OAM_SIZE      = 160,
    parameter logic [7:0]           OAM_MASK      = 8'hFF,
    parameter logic [ADDR_SIZE-1:0] VRAM_LOC      = 16'h8000,
    parameter int unsigned          VRAM_SIZE     = 8192,
    parameter logic [ADDR_SIZE-1:0] REG_LOC       = 16'hFF40,
    parameter int unsigned          LINE_CYCLES   = 456,
    parameter int unsigned          VISIBLE_LINES = 144,
    parameter int unsigned          FRAME_LINES   = 154
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_SIZE-1:0]     db_addr,
    input  logic [DATA_SIZE-1:0]     db_wdata,
    input  logic                     db_we,
    input  logic                     db_re,
    output logic [DATA_SIZE-1:0]     db_rdata,
    output logic                     drawline,
    output logic                     renderComplete,
    output logic [11*DATA_SIZE-1:0]  lcd
);

    localparam int unsigned OAM_AW    = $clog2(OAM_SIZE);
    localparam int unsigned VRAM_AW   = $clog2(VRAM_SIZE);
    localparam int unsigned DOT_W     = $clog2(LINE_CYCLES);
    localparam int unsigned REG_COUNT = 12;
    localparam int unsigned SCAN_END  = 80;
    localparam int unsigned XFER_END  = 252;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REG,
        SRC_OAM,
        SRC_VRAM
    } rd_src_e;

    // Address decode
    logic [ADDR_SIZE-1:0] oam_off_c, vram_off_c, reg_off_c;
    logic                 oam_hit_c, vram_hit_c, reg_hit_c;
    logic [OAM_AW-1:0]    oam_idx_c;
    logic [VRAM_AW-1:0]   vram_idx_c;
    logic [3:0]           reg_idx_c;

    assign oam_off_c  = db_addr - OAM_LOC;
    assign vram_off_c = db_addr - VRAM_LOC;
    assign reg_off_c  = db_addr - REG_LOC;
    assign oam_hit_c  = (db_addr >= OAM_LOC)  && (oam_off_c  < ADDR_SIZE'(OAM_SIZE));
    assign vram_hit_c = (db_addr >= VRAM_LOC) && (vram_off_c < ADDR_SIZE'(VRAM_SIZE));
    assign reg_hit_c  = (db_addr >= REG_LOC)  && (reg_off_c  < ADDR_SIZE'(REG_COUNT));
    assign oam_idx_c  = OAM_AW'(db_addr & ADDR_SIZE'(OAM_MASK));
    assign vram_idx_c = VRAM_AW'(vram_off_c);
    assign reg_idx_c  = 4'(reg_off_c);

    // Single-port read-first RAMs; contents survive reset
    logic [DATA_SIZE-1:0] oam_mem  [OAM_SIZE];
    logic [DATA_SIZE-1:0] vram_mem [VRAM_SIZE];
    logic [DATA_SIZE-1:0] oam_rd_q, vram_rd_q;

    always_ff @(posedge clk) begin
        if (oam_hit_c) begin
            if (db_we) oam_mem[oam_idx_c] <= db_wdata;
            if (db_re) oam_rd_q <= oam_mem[oam_idx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (vram_hit_c) begin
            if (db_we) vram_mem[vram_idx_c] <= db_wdata;
            if (db_re) vram_rd_q <= vram_mem[vram_idx_c];
        end
    end

    // Register file and timing state
    logic [DATA_SIZE-1:0] lcdc_q, scy_q, scx_q, ly_q, lyc_q, bgp_q, obp0_q, obp1_q, wy_q, wx_q;
    logic [DATA_SIZE-1:0] lcdc_d, scy_d, scx_d, ly_d, lyc_d, bgp_d, obp0_d, obp1_d, wy_d, wx_d;
    logic [3:0]           stat_q, stat_d;
    logic [DOT_W-1:0]     dot_q, dot_d;
    logic                 drawline_q, drawline_d, render_q, render_d;
    rd_src_e              rd_src_q, rd_src_d;
    logic [DATA_SIZE-1:0] reg_rd_q, reg_rd_d;
    logic [1:0]           mode_c;
    logic [DATA_SIZE-1:0] stat_rd_c, reg_val_c;
    logic                 ly_wr_c;

    always_comb begin
        if (!lcdc_q[7])                               mode_c = 2'd0;
        else if (ly_q >= DATA_SIZE'(VISIBLE_LINES))   mode_c = 2'd1;
        else if (dot_q < DOT_W'(SCAN_END))            mode_c = 2'd2;
        else if (dot_q < DOT_W'(XFER_END))            mode_c = 2'd3;
        else                                          mode_c = 2'd0;
    end

    assign stat_rd_c = {1'b1, stat_q, (ly_q == lyc_q), mode_c};

    always_comb begin
        reg_val_c = '1;
        case (reg_idx_c)
            4'h0:    reg_val_c = lcdc_q;
            4'h1:    reg_val_c = stat_rd_c;
            4'h2:    reg_val_c = scy_q;
            4'h3:    reg_val_c = scx_q;
            4'h4:    reg_val_c = ly_q;
            4'h5:    reg_val_c = lyc_q;
            4'h7:    reg_val_c = bgp_q;
            4'h8:    reg_val_c = obp0_q;
            4'h9:    reg_val_c = obp1_q;
            4'hA:    reg_val_c = wy_q;
            4'hB:    reg_val_c = wx_q;
            default: reg_val_c = '1;
        endcase
    end

    always_comb begin
        lcdc_d   = lcdc_q;
        stat_d   = stat_q;
        scy_d    = scy_q;
        scx_d    = scx_q;
        lyc_d    = lyc_q;
        bgp_d    = bgp_q;
        obp0_d   = obp0_q;
        obp1_d   = obp1_q;
        wy_d     = wy_q;
        wx_d     = wx_q;
        ly_d     = ly_q;
        dot_d    = dot_q;
        rd_src_d = rd_src_q;
        reg_rd_d = reg_rd_q;
        ly_wr_c  = db_we && reg_hit_c && (reg_idx_c == 4'h4);

        if (db_we && reg_hit_c) begin
            case (reg_idx_c)
                4'h0:    lcdc_d = db_wdata;
                4'h1:    stat_d = db_wdata[6:3];
                4'h2:    scy_d  = db_wdata;
                4'h3:    scx_d  = db_wdata;
                4'h5:    lyc_d  = db_wdata;
                4'h7:    bgp_d  = db_wdata;
                4'h8:    obp0_d = db_wdata;
                4'h9:    obp1_d = db_wdata;
                4'hA:    wy_d   = db_wdata;
                4'hB:    wx_d   = db_wdata;
                default: ;
            endcase
        end

        if (db_re) begin
            if (oam_hit_c) begin
                rd_src_d = SRC_OAM;
            end else if (vram_hit_c) begin
                rd_src_d = SRC_VRAM;
            end else begin
                rd_src_d = SRC_REG;
                reg_rd_d = reg_hit_c ? reg_val_c : '1;
            end
        end

        // Counters hold at zero while the LCD is off or being switched off
        if (!lcdc_q[7] || !lcdc_d[7] || ly_wr_c) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (dot_q == DOT_W'(LINE_CYCLES - 1)) begin
            dot_d = '0;
            ly_d  = (ly_q == DATA_SIZE'(FRAME_LINES - 1)) ? '0 : ly_q + DATA_SIZE'(1);
        end else begin
            dot_d = dot_q + DOT_W'(1);
        end

        drawline_d = lcdc_d[7] && (dot_d == '0) && (ly_d < DATA_SIZE'(VISIBLE_LINES));
        render_d   = lcdc_d[7] && (ly_q == DATA_SIZE'(VISIBLE_LINES - 1))
                               && (ly_d == DATA_SIZE'(VISIBLE_LINES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcdc_q     <= '0;
            stat_q     <= '0;
            scy_q      <= '0;
            scx_q      <= '0;
            ly_q       <= '0;
            lyc_q      <= '0;
            bgp_q      <= '0;
            obp0_q     <= '0;
            obp1_q     <= '0;
            wy_q       <= '0;
            wx_q       <= '0;
            dot_q      <= '0;
            drawline_q <= 1'b0;
            render_q   <= 1'b0;
            rd_src_q   <= SRC_NONE;
            reg_rd_q   <= '0;
        end else begin
            lcdc_q     <= lcdc_d;
            stat_q     <= stat_d;
            scy_q      <= scy_d;
            scx_q      <= scx_d;
            ly_q       <= ly_d;
            lyc_q      <= lyc_d;
            bgp_q      <= bgp_d;
            obp0_q     <= obp0_d;
            obp1_q     <= obp1_d;
            wy_q       <= wy_d;
            wx_q       <= wx_d;
            dot_q      <= dot_d;
            drawline_q <= drawline_d;
            render_q   <= render_d;
            rd_src_q   <= rd_src_d;
            reg_rd_q   <= reg_rd_d;
        end
    end

    // Read data comes straight from whichever source register the last read loaded
    always_comb begin
        case (rd_src_q)
            SRC_REG:  db_rdata = reg_rd_q;
            SRC_OAM:  db_rdata = oam_rd_q;
            SRC_VRAM: db_rdata = vram_rd_q;
            default:  db_rdata = '0;
        endcase
    end

    assign drawline       = drawline_q;
    assign renderComplete = render_q;
    assign lcd = {lcdc_q, stat_rd_c, scy_q, scx_q, ly_q, lyc_q, bgp_q, obp0_q, obp1_q, wy_q, wx_q};

endmodule

// File: tb/tb_whiz_graphics.sv
// Scoreboard bench for whiz_graphics: bus reads are checked by a monitor, timing
// strobes and the lcd bus against a dot/line model derived from elapsed cycles.
module tb_whiz_graphics;

    localparam int LINE  = 456;
    localparam int LINES = 154;
    localparam int FRAME = LINES * LINE;
    localparam int T_RST = FRAME + 7 * LINE + 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] db_addr;
    logic [7:0]  db_wdata;
    logic        db_we, db_re;
    logic [7:0]  db_rdata;
    logic        drawline, renderComplete;
    logic [87:0] lcd;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  val;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       rvalid = 1'b0;
    logic [7:0] oam_model [160];

    whiz_graphics dut (
        .clk            (clk),
        .rst            (rst),
        .db_addr        (db_addr),
        .db_wdata       (db_wdata),
        .db_we          (db_we),
        .db_re          (db_re),
        .db_rdata       (db_rdata),
        .drawline       (drawline),
        .renderComplete (renderComplete),
        .lcd            (lcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input logic [87:0] act, input logic [87:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        db_we    = we;
        db_re    = re;
        db_addr  = a;
        db_wdata = d;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        exp_t x;
        cyc(1'b0, 1'b1, a, 8'h00);
        x.addr = a;
        x.val  = e;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Read monitor: one cycle after each read strobe the data must match the queue head
    always @(posedge clk) rvalid <= db_re && !rst;

    always @(negedge clk) begin
        exp_t e;
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read_unexpected: got %h with no read pending", db_rdata);
            end else begin
                e = exp_q.pop_front();
                check("read", int'(e.addr), 88'(db_rdata), 88'(e.val));
            end
        end
    end

    initial begin
        int         dot, line, dl_cnt, rc_cnt;
        logic [1:0] emode;
        logic [7:0] d;
        logic [17:0] exp_t18, act_t18;

        rst = 1'b1;
        db_we = 1'b0; db_re = 1'b0; db_addr = '0; db_wdata = '0;
        dl_cnt = 0; rc_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_rdata", 0, 88'(db_rdata), 88'h0);
        check("reset_pulses", 0, 88'({drawline, renderComplete}), 88'h0);
        check("reset_lcd", 0, lcd, {8'h00, 8'h84, 72'h0});
        rst = 1'b0;

        // OAM write then immediate readback
        for (int i = 0; i < 160; i++) begin
            d = 8'($urandom);
            oam_model[i] = d;
            wr(16'hFE00 + 16'(i), d);
            rd(16'hFE00 + 16'(i), d);
        end

        // VRAM ends, unmapped and DMA holes, read-before-write collision
        wr(16'h8000, 8'h5A);
        wr(16'h9FFF, 8'hA5);
        rd(16'h8000, 8'h5A);
        rd(16'h9FFF, 8'hA5);
        rd(16'hFEA0, 8'hFF);
        rd(16'h0000, 8'hFF);
        rd(16'hFF46, 8'hFF);
        cyc(1'b1, 1'b1, 16'h8000, 8'h77);
        exp_q.push_back('{addr: 16'h8000, val: 8'h5A});
        rd(16'h8000, 8'h77);

        // Register file
        wr(16'hFF47, 8'hE4);
        wr(16'hFF42, 8'h10);
        rd(16'hFF47, 8'hE4);
        rd(16'hFF42, 8'h10);
        check("lcd_bgp", 0, 88'(lcd[39:32]), 88'hE4);
        check("lcd_scy", 0, 88'(lcd[71:64]), 88'h10);
        wr(16'hFF44, 8'h33);
        rd(16'hFF44, 8'h00);
        wr(16'hFF41, 8'hFF);
        rd(16'hFF41, 8'hFC);
        wr(16'hFF41, 8'h00);
        wr(16'hFF45, 8'h05);
        rd(16'hFF47, 8'hE4);
        check("stat_lyc_off", 0, 88'(lcd[79:72]), 88'h80);

        // Enable the LCD and follow the timing cycle by cycle
        wr(16'hFF40, 8'h80);
        for (int t = 0; t < T_RST; t++) begin
            idle();
            dot  = t % LINE;
            line = (t / LINE) % LINES;
            if (line >= 144)     emode = 2'd1;
            else if (dot < 80)   emode = 2'd2;
            else if (dot < 252)  emode = 2'd3;
            else                 emode = 2'd0;
            exp_t18 = {(dot == 0 && line < 144), (dot == 0 && line == 144),
                       1'b1, 4'b0000, (line == 5), emode, 8'(line)};
            act_t18 = {drawline, renderComplete, lcd[79:72], lcd[55:48]};
            check("timing", t, 88'(act_t18), 88'(exp_t18));
            if (drawline) dl_cnt++;
            if (renderComplete) rc_cnt++;
        end
        check("drawline_count", 0, 88'(dl_cnt), 88'(152));
        check("render_count", 0, 88'(rc_cnt), 88'(1));
        check("rdata_hold", 0, 88'(db_rdata), 88'hE4);

        // Mid-frame reset
        idle();
        rst = 1'b1;
        idle();
        check("midreset_rdata", 0, 88'(db_rdata), 88'h0);
        check("midreset_pulses", 0, 88'({drawline, renderComplete}), 88'h0);
        check("midreset_lcd", 0, lcd, {8'h00, 8'h84, 72'h0});
        idle();
        rst = 1'b0;
        for (int t = 0; t < 600; t++) begin
            idle();
            check("post_reset_quiet", t, 88'({drawline, renderComplete, lcd[55:48]}), 88'h0);
        end

        for (int i = 0; i < 160; i++) rd(16'hFE00 + 16'(i), oam_model[i]);

        repeat (3) idle();
        check("queue_drain", 0, 88'(exp_q.size()), 88'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
